// File: rtl/key_input_pkg.sv
// ============================================================================
// Module      : key_input_pkg
// Description : Register offsets and bit positions for the key/switch input
//               peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_input_pkg;

  localparam logic [1:0] KEY_LEVEL = 2'd0;
  localparam logic [1:0] KEY_EDGE  = 2'd1;
  localparam logic [1:0] KEY_CTRL  = 2'd2;
  localparam logic [1:0] KEY_RSVD  = 2'd3;

  localparam int SW_LSB = 16;

endpackage

`default_nettype wire

// File: rtl/key_input_if.sv
// ============================================================================
// Module      : key_input_if
// Description : CPU data-bus window of the key/switch input peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_input_if;

  logic [1:0]  Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        irq;

  modport master (
    output Address, MemRead, MemWrite, Write_data,
    input  Read_data, irq
  );

  modport slave (
    input  Address, MemRead, MemWrite, Write_data,
    output Read_data, irq
  );

endinterface

`default_nettype wire

// File: rtl/key_input_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : One-bit 2-flop synchroniser followed by a stable-count
//               debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_raw,
  output logic      o_deb
);

  localparam int              CW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(DEB_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the synced input disagrees with the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_deb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_deb <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_deb = r_deb;

endmodule

`default_nettype wire

// File: rtl/key_input.sv
// ============================================================================
// Module      : key_input
// Description : Memory-mapped push-button / slide-switch input peripheral with
//               sticky press flags and a maskable interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_input
  import key_input_pkg::*;
#(
  parameter int          NKEYS      = 4,
  parameter int          NSW        = 8,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [NKEYS-1:0] keys_raw,
  input  wire logic [NSW-1:0]   sw_raw,
  key_input_if.slave            bus
);

  logic [NKEYS-1:0] w_key_deb;
  logic [NSW-1:0]   w_sw_deb;
  logic [NKEYS-1:0] w_press;
  logic [NKEYS-1:0] w_clr;
  logic             w_wr_ctrl;
  logic [31:0]      w_rd;
  logic             w_unused;

  logic [NKEYS-1:0] r_key_prev;
  logic [NKEYS-1:0] r_edge;
  logic [NKEYS-1:0] r_ie;
  logic             r_irq;

  generate
    for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .reset (reset),
        .i_raw (keys_raw[i]),
        .o_deb (w_key_deb[i])
      );
    end
    for (genvar j = 0; j < NSW; j++) begin : g_sw
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .reset (reset),
        .i_raw (sw_raw[j]),
        .o_deb (w_sw_deb[j])
      );
    end
  endgenerate

  assign w_press   = w_key_deb & ~r_key_prev;
  assign w_clr     = (bus.MemWrite && bus.Address == KEY_EDGE) ? bus.Write_data[NKEYS-1:0] : '0;
  assign w_wr_ctrl = bus.MemWrite && (bus.Address == KEY_CTRL);

  // Press is OR-ed after the clear so a same-cycle W1C never drops a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_key_prev <= '0;
      r_edge     <= '0;
      r_ie       <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_key_prev <= w_key_deb;
      r_edge     <= (r_edge & ~w_clr) | w_press;
      if (w_wr_ctrl) begin
        r_ie <= bus.Write_data[NKEYS-1:0];
      end
      r_irq      <= |(r_edge & r_ie);
    end
  end

  always_comb begin
    w_rd = '0;
    if (reset) begin
      case (bus.Address)
        KEY_LEVEL: begin
          w_rd[NKEYS-1:0]     = w_key_deb;
          w_rd[SW_LSB +: NSW] = w_sw_deb;
        end
        KEY_EDGE: w_rd[NKEYS-1:0] = r_edge;
        KEY_CTRL: w_rd[NKEYS-1:0] = r_ie;
        default:  w_rd = '0;
      endcase
    end
  end

  assign bus.Read_data = w_rd;
  assign bus.irq       = r_irq;

  // Loads have no side effects, and store bits above the key field are ignored.
  assign w_unused = ^{bus.MemRead, bus.Write_data};

endmodule

`default_nettype wire

// File: tb/tb_key_input.sv
// ============================================================================
// Module      : tb_key_input
// Description : Self-checking bench for key_input with a stable-run reference
//               model of the debounced inputs and the press/interrupt registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_input;

  localparam int NK  = 4;
  localparam int NS  = 8;
  localparam int DEB = 4;
  localparam int NB  = NK + NS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] keys_raw = '0;
  logic [NS-1:0] sw_raw = '0;

  int checks = 0;
  int errors = 0;

  key_input_if bus ();

  key_input #(.NKEYS(NK), .NSW(NS), .DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .reset    (reset),
    .keys_raw (keys_raw),
    .sw_raw   (sw_raw),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: an input's debounced value flips once its synced value
  // (the raw value two clocks earlier) has differed from it for DEB samples in a row.
  logic [NB-1:0] m_s1, m_s2, m_deb, m_runv;
  int            m_run [NB];
  logic [NK-1:0] m_prev, m_edge, m_ie, m_press;
  logic          m_irq;

  initial begin
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_runv = '0;
    m_prev = '0; m_edge = '0; m_ie = '0; m_irq = 1'b0;
    for (int i = 0; i < NB; i++) m_run[i] = 0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_runv = '0;
      m_prev = '0; m_edge = '0; m_ie = '0; m_irq = 1'b0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      m_press = m_deb[NK-1:0] & ~m_prev;
      m_irq   = |(m_edge & m_ie);
      if (bus.MemWrite && bus.Address == 2'd1) m_edge = m_edge & ~bus.Write_data[NK-1:0];
      m_edge = m_edge | m_press;
      if (bus.MemWrite && bus.Address == 2'd2) m_ie = bus.Write_data[NK-1:0];
      m_prev = m_deb[NK-1:0];
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] == m_runv[i]) m_run[i]++;
        else begin
          m_runv[i] = m_s2[i];
          m_run[i]  = 1;
        end
        if (m_run[i] == DEB && m_runv[i] != m_deb[i]) m_deb[i] = m_runv[i];
      end
      m_s2 = m_s1;
      m_s1 = {sw_raw, keys_raw};
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    if (reset) begin
      case (a)
        2'd0: begin v[NK-1:0] = m_deb[NK-1:0]; v[16 +: NS] = m_deb[NB-1:NK]; end
        2'd1: v[NK-1:0] = m_edge;
        2'd2: v[NK-1:0] = m_ie;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Address = a;
    #1;
    d = bus.Read_data;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Address    = a;
    bus.Write_data = d;
    bus.MemWrite   = 1'b1;
    @(negedge clk);
    bus.MemWrite   = 1'b0;
    bus.Write_data = '0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    keys_raw = 4'hF;
    cyc(3);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_read off%0d: got %h want %h", a, d, 32'h0); end
    end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    reset = 1'b1;
    cyc(5);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_level_early: got %h want %h", d, 32'h0); end
    cyc(1);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0000_000F) begin errors++; $display("FAIL reset_level_6: got %h want %h", d, 32'h0000_000F); end
    cyc(1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_000F) begin errors++; $display("FAIL reset_edge: got %h want %h", d, 32'h0000_000F); end
    keys_raw = '0;
    wr(2'd1, 32'hF);
    cyc(8);
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    keys_raw[0] = 1'b1;
    cyc(3);
    keys_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd(2'd0, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL glitch_level cyc%0d: got %h want %h", k, d, 32'h0); end
      cyc(1);
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_edge: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_press_irq;
    logic [31:0] d;
    int n;
    wr(2'd2, 32'h1);
    keys_raw[0] = 1'b1;
    n = 0;
    rd(2'd0, d);
    while (d[0] !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
      rd(2'd0, d);
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL press_latency: got %0d cycles want 6", n); end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL press_edge_early: got %h want %h", d, 32'h0); end
    cyc(1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h1 || bus.irq !== 1'b0) begin errors++; $display("FAIL press_edge: got edge %h irq %b want 1 / 0", d, bus.irq); end
    cyc(1);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL press_irq: got %b want 1", bus.irq); end
    wr(2'd1, 32'h1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL w1c_edge: got %h want %h", d, 32'h0); end
    cyc(1);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", bus.irq); end
    keys_raw[0] = 1'b0;
    cyc(8);
  endtask

  task automatic test_collision;
    logic [31:0] d;
    keys_raw[1] = 1'b1;
    cyc(6);
    rd(2'd0, d);
    checks++;
    if (d[1] !== 1'b1) begin errors++; $display("FAIL collide_level: got %h want bit1 set", d); end
    wr(2'd1, 32'h2);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL collide_set_wins: got %h want %h", d, 32'h2); end
    keys_raw[1] = 1'b0;
    wr(2'd1, 32'hF);
    cyc(10);
  endtask

  task automatic test_switches;
    logic [31:0] d;
    sw_raw = 8'hA5;
    cyc(5);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL sw_level_early: got %h want %h", d, 32'h0); end
    cyc(1);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h00A5_0000) begin errors++; $display("FAIL sw_level: got %h want %h", d, 32'h00A5_0000); end
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h00A5_0000) begin errors++; $display("FAIL ro_level: got %h want %h", d, 32'h00A5_0000); end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ro_edge: got %h want %h", d, 32'h0); end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL ro_ctrl: got %h want %h", d, 32'h1); end
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rsvd_read: got %h want %h", d, 32'h0); end
    sw_raw = '0;
    cyc(8);
  endtask

  task automatic test_masking;
    logic [31:0] d;
    wr(2'd2, 32'h9);
    keys_raw = 4'b0110;
    cyc(9);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL mask_edge: got %h want %h", d, 32'h6); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b want 0", bus.irq); end
    wr(2'd2, 32'h4);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_irq_lag: got %b want 0", bus.irq); end
    cyc(1);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL mask_irq_on: got %b want 1", bus.irq); end
    keys_raw = '0;
    wr(2'd2, 32'h0);
    wr(2'd1, 32'hF);
    cyc(8);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    keys_raw = 4'h8;
    cyc(4);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(5);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midrst_level_early: got %h want %h", d, 32'h0); end
    cyc(1);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL midrst_level: got %h want %h", d, 32'h8); end
    cyc(1);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL midrst_edge: got %h want %h", d, 32'h8); end
    keys_raw = '0;
    wr(2'd1, 32'hF);
    cyc(8);
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [31:0] e;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < NK; b++) if ($urandom_range(0, 5) == 0) keys_raw[b] = ~keys_raw[b];
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 7) == 0) sw_raw[b] = ~sw_raw[b];
      reset          = ($urandom_range(0, 149) != 0);
      bus.MemRead    = 1'($urandom_range(0, 1));
      bus.MemWrite   = ($urandom_range(0, 5) == 0);
      bus.Write_data = $urandom;
      bus.Address    = 2'($urandom_range(0, 3));
      #1;
      d = bus.Read_data;
      e = exp_rd(bus.Address);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rand_read cyc%0d off%0d: got %h want %h", k, bus.Address, d, e); end
      checks++;
      if (bus.irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc%0d: got %b want %b", k, bus.irq, m_irq); end
      cyc(1);
    end
    bus.MemWrite = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    bus.Address    = '0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.Write_data = '0;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_press_irq();
    test_collision();
    test_switches();
    test_masking();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_input.md
Name: key_input

Overview:
Memory-mapped input peripheral on the CPU data bus. It is the read-direction counterpart of the seven-segment output register.
- Synchronises and debounces board push-buttons and slide switches.
- Latches a sticky flag on each button press.
- Presents level, edge and control registers for CPU loads through the data-memory mux.
- Raises an interrupt request when an enabled press flag is set.

Parameters:
NKEYS, 4, number of push-buttons (1..8)
NSW, 8, number of slide switches (1..16)
DEB_CYCLES, 20'd500000, stable cycles a key must hold before its debounced level changes (at least 2)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous active-low reset; state clears on a rising clk edge while reset==0
keys_raw  input  NKEYS  asynchronous push-button levels, 1 = pressed
sw_raw  input  NSW  asynchronous switch levels
Address  input  2  word offset in peripheral window: 0 LEVEL, 1 EDGE, 2 CTRL, 3 reserved
MemRead  input  1  CPU load strobe for this window
MemWrite  input  1  CPU store strobe for this window
Write_data  input  32  store data
Read_data  output  32  load data, combinational from registered state
irq  output  1  interrupt request, registered

Behaviour:
Reset (reset==0 at a clk edge):
- Synchronisers, debounce counters, debounced levels, EDGE, CTRL and irq all clear to 0.
- Read_data reads 0 for every offset while reset is held.

Input path:
- Each raw bit passes a 2-flop synchroniser.
- Per bit, the counter resets to 0 whenever the synced value equals the debounced value; otherwise it increments.
- When the counter reaches DEB_CYCLES-1, the debounced value takes the synced value and the counter resets to 0.
- Latency from a stable raw change to the debounced change is 2 + DEB_CYCLES cycles.
- Glitches shorter than DEB_CYCLES cycles never change the debounced value.

Press detection:
- A rising edge of a debounced key (0->1) sets EDGE[i] one cycle after the level change.
- Release edges are ignored.

Register map (read):
- LEVEL: {zero pad, sw_deb[NSW-1:0] at bits [NSW+15:16], zero pad, key_deb[NKEYS-1:0] at bits [NKEYS-1:0]}.
- EDGE: {zero pad, EDGE[NKEYS-1:0]}.
- CTRL: {zero pad, IE[NKEYS-1:0]}.
- Offset 3 reads 0.
- Read_data is driven regardless of MemRead. Loads have no side effects.

Register map (write, on the clk edge with MemWrite=1):
- LEVEL: ignored.
- EDGE: write-1-to-clear; EDGE[i] clears where Write_data[i]==1.
- CTRL: IE <= Write_data[NKEYS-1:0].
- Offset 3: ignored.

Simultaneous events:
- A new press on key i in the same cycle as a W1C of bit i leaves EDGE[i]=1 (set wins). The press is never lost.

Interrupt:
- irq <= |(EDGE & IE), registered, so it follows EDGE/IE changes by one cycle.
- irq stays high until software clears every enabled set flag or disables it.

Reset mid-debounce:
- Any partial count is discarded.
- After reset, a key held pressed must be stable for the full DEB_CYCLES before it is seen. It then produces an EDGE flag, because the debounced value was 0 after reset.

Width rules:
- Counter width is $clog2(DEB_CYCLES).
- Unused Read_data bits are 0.

Decomposition:
Shared package key_input_pkg:
- Register offset constants KEY_LEVEL=2'd0, KEY_EDGE=2'd1, KEY_CTRL=2'd2.
- Bit-position constant SW_LSB=16.

One natural sub-module:
- key_debounce: 1-bit synchroniser plus counter plus debounced output, parameterised by DEB_CYCLES.
- Instantiated NKEYS+NSW times via generate.
- key_input holds the edge, control, irq and read-mux logic.

Test Plan (DEB_CYCLES=4 in the bench):
- Reset: hold reset=0 for 3 cycles with keys_raw=4'hF -> Read_data=0 at all offsets and irq=0. After release, LEVEL=32'h0000_000F exactly 6 cycles after the first post-reset edge.
- Glitch reject: pulse keys_raw[0]=1 for 3 cycles -> LEVEL bit0 stays 0 and EDGE stays 0.
- Press and IRQ: write CTRL=1, then hold keys_raw[0]=1 -> EDGE=32'h1 one cycle after LEVEL bit0 rises, and irq=1 one cycle after that. Write EDGE=1 -> EDGE=0 and irq=0 on the following cycle.
- Set-wins collision: time a W1C of EDGE bit1 on the exact cycle key1's debounced level rises -> EDGE bit1 reads 1 afterwards.
- Switches: sw_raw=8'hA5 stable -> LEVEL=32'h00A5_0000 after 6 cycles. Writes to LEVEL and offset 3 change nothing.
- Masking: EDGE=4'b0110 with IE=4'b1001 -> irq=0. Write CTRL=4'b0100 -> irq=1 one cycle later.
